control_sequencer: RTL and testbench

//  Hardwired control unit directly upstream of the register select/encode stage. Decodes IR,

---
 rtl/cpu_ctl_pkg.sv | 80 ++++++++
 rtl/ctl_class_decode.sv | 46 ++++
 rtl/control_sequencer.sv | 148 ++++++++++++++
 tb/tb_control_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, T-state codes,
// instruction classes and the dp_ctl strobe index map.
package cpu_ctl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  // T0..T7 encode their step number so state[2:0] is the step and state[3] marks idle states.
  typedef enum logic [3:0] {
    T0      = 4'd0,
    T1      = 4'd1,
    T2      = 4'd2,
    T3      = 4'd3,
    T4      = 4'd4,
    T5      = 4'd5,
    T6      = 4'd6,
    T7      = 4'd7,
    S_RST   = 4'd8,
    S_PAUSE = 4'd9,
    S_HALT  = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_UNARY, C_MULDIV, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } ins_class_e;

  localparam int unsigned DP_PC_OUT     = 0;
  localparam int unsigned DP_PC_IN      = 1;
  localparam int unsigned DP_INC_PC     = 2;
  localparam int unsigned DP_MAR_IN     = 3;
  localparam int unsigned DP_MDR_IN     = 4;
  localparam int unsigned DP_MDR_OUT    = 5;
  localparam int unsigned DP_MEM_READ   = 6;
  localparam int unsigned DP_MEM_WRITE  = 7;
  localparam int unsigned DP_IR_IN      = 8;
  localparam int unsigned DP_Y_IN       = 9;
  localparam int unsigned DP_Z_IN       = 10;
  localparam int unsigned DP_Z_LO_OUT   = 11;
  localparam int unsigned DP_Z_HI_OUT   = 12;
  localparam int unsigned DP_HI_IN      = 13;
  localparam int unsigned DP_LO_IN      = 14;
  localparam int unsigned DP_HI_OUT     = 15;
  localparam int unsigned DP_LO_OUT     = 16;
  localparam int unsigned DP_C_OUT      = 17;
  localparam int unsigned DP_CON_IN     = 18;
  localparam int unsigned DP_INPORT_OUT = 19;
  localparam int unsigned DP_OUTPORT_IN = 20;
  localparam int unsigned DP_SPARE      = 21;
  localparam int unsigned DP_WIDTH      = 22;

endpackage

// File: rtl/ctl_class_decode.sv
// Combinational opcode decode into an instruction class and the T-step on which that
// instruction finishes.
module ctl_class_decode
  import cpu_ctl_pkg::*;
(
  input  logic [4:0]  opcode,
  output ins_class_e  ins_class,
  output logic [2:0]  last_step
);

  always_comb begin
    ins_class = C_NOP;
    last_step = 3'd2;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: begin
        ins_class = C_ALU_R;
        last_step = 3'd5;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        ins_class = C_ALU_I;
        last_step = 3'd5;
      end
      OP_NEG, OP_NOT: begin
        ins_class = C_UNARY;
        last_step = 3'd4;
      end
      OP_MUL, OP_DIV: begin
        ins_class = C_MULDIV;
        last_step = 3'd6;
      end
      OP_LD:   begin ins_class = C_LD;   last_step = 3'd7; end
      OP_LDI:  begin ins_class = C_LDI;  last_step = 3'd5; end
      OP_ST:   begin ins_class = C_ST;   last_step = 3'd7; end
      OP_BR:   begin ins_class = C_BR;   last_step = 3'd6; end
      OP_JR:   begin ins_class = C_JR;   last_step = 3'd3; end
      OP_JAL:  begin ins_class = C_JAL;  last_step = 3'd4; end
      OP_IN:   begin ins_class = C_IN;   last_step = 3'd3; end
      OP_OUT:  begin ins_class = C_OUT;  last_step = 3'd3; end
      OP_MFHI: begin ins_class = C_MFHI; last_step = 3'd3; end
      OP_MFLO: begin ins_class = C_MFLO; last_step = 3'd3; end
      OP_HALT: begin ins_class = C_HALT; last_step = 3'd3; end
      default: begin ins_class = C_NOP;  last_step = 3'd2; end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired T-state control unit: fetch in T0-T2, class-specific execute in T3-T7,
// Moore outputs decoded from the state register, ir and con_ff.
module control_sequencer
  import cpu_ctl_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic                stop,
  input  logic [31:0]         ir,
  input  logic                con_ff,
  output logic [5:0]          reg_sel,
  output logic [DP_WIDTH-1:0] dp_ctl,
  output logic [4:0]          alu_op,
  output logic                run
);

  state_e     state_q, state_d;
  ins_class_e ins_class;
  logic [2:0] last_step;
  logic       gra, grb, grc, r_in, r_out, ba_out;
  logic [DP_WIDTH-1:0] dp;

  // Register fields are consumed by the select/encode stage, not here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  ctl_class_decode u_decode (
    .opcode    (ir[31:27]),
    .ins_class (ins_class),
    .last_step (last_step)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_RST;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = T0;
      S_PAUSE: state_d = stop ? S_PAUSE : T0;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == T3 && ins_class == C_HALT) begin
          state_d = S_HALT;
        end else if (state_q[2:0] == last_step) begin
          state_d = stop ? S_PAUSE : T0;
        end else begin
          state_d = state_e'(state_q + 4'd1);
        end
      end
    endcase
  end

  always_comb begin
    gra = 1'b0; grb = 1'b0; grc = 1'b0; r_in = 1'b0; r_out = 1'b0; ba_out = 1'b0;
    dp     = '0;
    alu_op = 5'd0;
    case (state_q)
      T0: begin
        dp[DP_PC_OUT] = 1'b1; dp[DP_MAR_IN] = 1'b1; dp[DP_INC_PC] = 1'b1; dp[DP_Z_IN] = 1'b1;
      end
      T1: begin
        dp[DP_Z_LO_OUT] = 1'b1; dp[DP_PC_IN] = 1'b1; dp[DP_MEM_READ] = 1'b1;
        dp[DP_MDR_IN] = 1'b1;
      end
      T2: begin
        dp[DP_MDR_OUT] = 1'b1; dp[DP_IR_IN] = 1'b1;
      end
      T3, T4, T5, T6, T7: begin
        case (ins_class)
          C_ALU_R: case (state_q)
            T3: begin grb = 1'b1; r_out = 1'b1; dp[DP_Y_IN] = 1'b1; end
            T4: begin grc = 1'b1; r_out = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ir[31:27]; end
            T5: begin dp[DP_Z_LO_OUT] = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default: ;
          endcase
          C_ALU_I: case (state_q)
            T3: begin grb = 1'b1; r_out = 1'b1; dp[DP_Y_IN] = 1'b1; end
            T4: begin dp[DP_C_OUT] = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ir[31:27]; end
            T5: begin dp[DP_Z_LO_OUT] = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default: ;
          endcase
          C_UNARY: case (state_q)
            T3: begin grb = 1'b1; r_out = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ir[31:27]; end
            T4: begin dp[DP_Z_LO_OUT] = 1'b1; gra = 1'b1; r_in = 1'b1; end
            default: ;
          endcase
          C_MULDIV: case (state_q)
            T3: begin gra = 1'b1; r_out = 1'b1; dp[DP_Y_IN] = 1'b1; end
            T4: begin grb = 1'b1; r_out = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ir[31:27]; end
            T5: begin dp[DP_Z_LO_OUT] = 1'b1; dp[DP_LO_IN] = 1'b1; end
            T6: begin dp[DP_Z_HI_OUT] = 1'b1; dp[DP_HI_IN] = 1'b1; end
            default: ;
          endcase
          // ld, ldi and st share the base+offset address computation through T5.
          C_LD, C_LDI, C_ST: case (state_q)
            T3: begin grb = 1'b1; ba_out = 1'b1; dp[DP_Y_IN] = 1'b1; end
            T4: begin dp[DP_C_OUT] = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ALU_ADD; end
            T5: begin
              dp[DP_Z_LO_OUT] = 1'b1;
              if (ins_class == C_LDI) begin gra = 1'b1; r_in = 1'b1; end
              else                    dp[DP_MAR_IN] = 1'b1;
            end
            T6: begin
              dp[DP_MDR_IN] = 1'b1;
              if (ins_class == C_LD) dp[DP_MEM_READ] = 1'b1;
              else begin gra = 1'b1; r_out = 1'b1; end
            end
            T7: begin
              if (ins_class == C_LD) begin
                dp[DP_MDR_OUT] = 1'b1; gra = 1'b1; r_in = 1'b1;
              end else begin
                dp[DP_MEM_WRITE] = 1'b1;
              end
            end
            default: ;
          endcase
          C_BR: case (state_q)
            T3: begin gra = 1'b1; r_out = 1'b1; dp[DP_CON_IN] = 1'b1; end
            T4: begin dp[DP_PC_OUT] = 1'b1; dp[DP_Y_IN] = 1'b1; end
            T5: begin dp[DP_C_OUT] = 1'b1; dp[DP_Z_IN] = 1'b1; alu_op = ALU_ADD; end
            T6: begin dp[DP_Z_LO_OUT] = 1'b1; dp[DP_PC_IN] = con_ff; end
            default: ;
          endcase
          C_JR: if (state_q == T3) begin gra = 1'b1; r_out = 1'b1; dp[DP_PC_IN] = 1'b1; end
          C_JAL: case (state_q)
            T3: begin grb = 1'b1; r_in = 1'b1; dp[DP_PC_OUT] = 1'b1; end
            T4: begin gra = 1'b1; r_out = 1'b1; dp[DP_PC_IN] = 1'b1; end
            default: ;
          endcase
          C_IN:   if (state_q == T3) begin gra = 1'b1; r_in = 1'b1; dp[DP_INPORT_OUT] = 1'b1; end
          C_OUT:  if (state_q == T3) begin gra = 1'b1; r_out = 1'b1; dp[DP_OUTPORT_IN] = 1'b1; end
          C_MFHI: if (state_q == T3) begin gra = 1'b1; r_in = 1'b1; dp[DP_HI_OUT] = 1'b1; end
          C_MFLO: if (state_q == T3) begin gra = 1'b1; r_in = 1'b1; dp[DP_LO_OUT] = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign reg_sel = {gra, grb, grc, r_in, r_out, ba_out};
  assign dp_ctl  = dp;
  assign run     = ~state_q[3];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks fetch/execute of several instruction
// classes, pause, halt and mid-instruction reset, with per-cycle invariant checks.
module tb_control_sequencer;
  import cpu_ctl_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n, stop, con_ff;
  logic [31:0] ir;
  logic [5:0]  reg_sel;
  logic [21:0] dp_ctl;
  logic [4:0]  alu_op;
  logic        run;

  int n_tests = 0;
  int n_fail  = 0;
  bit inv_en  = 1'b0;

  localparam logic [5:0] RS_GRA = 6'b100000, RS_GRB = 6'b010000, RS_GRC = 6'b001000;
  localparam logic [5:0] RS_RIN = 6'b000100, RS_ROUT = 6'b000010, RS_BA = 6'b000001;

  localparam logic [21:0] M_T0 = (22'd1 << DP_PC_OUT) | (22'd1 << DP_MAR_IN) |
                                 (22'd1 << DP_INC_PC) | (22'd1 << DP_Z_IN);
  localparam logic [21:0] M_T1 = (22'd1 << DP_Z_LO_OUT) | (22'd1 << DP_PC_IN) |
                                 (22'd1 << DP_MEM_READ) | (22'd1 << DP_MDR_IN);
  localparam logic [21:0] M_T2 = (22'd1 << DP_MDR_OUT) | (22'd1 << DP_IR_IN);

  control_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .stop    (stop),
    .ir      (ir),
    .con_ff  (con_ff),
    .reg_sel (reg_sel),
    .dp_ctl  (dp_ctl),
    .alu_op  (alu_op),
    .run     (run)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] rs, input logic [21:0] dp,
                            input logic r);
    check({tag, "_rs"},  {26'd0, reg_sel}, {26'd0, rs});
    check({tag, "_dp"},  {10'd0, dp_ctl},  {10'd0, dp});
    check({tag, "_run"}, {31'd0, run},     {31'd0, r});
  endtask

  // Invariants evaluated mid-cycle, away from the active edge.
  always @(negedge clock) begin
    if (inv_en) begin
      check("inv_gr", {31'd0, $countones(reg_sel[5:3]) <= 1}, 32'd1);
      check("inv_rin_rout", {31'd0, reg_sel[2] & (reg_sel[1] | reg_sel[0])}, 32'd0);
      check("inv_bus", {31'd0, $countones({reg_sel[1], reg_sel[0], dp_ctl[DP_PC_OUT],
            dp_ctl[DP_MDR_OUT], dp_ctl[DP_Z_LO_OUT], dp_ctl[DP_Z_HI_OUT], dp_ctl[DP_HI_OUT],
            dp_ctl[DP_LO_OUT], dp_ctl[DP_C_OUT], dp_ctl[DP_INPORT_OUT]}) <= 1}, 32'd1);
      check("inv_mem", {31'd0, dp_ctl[DP_MEM_READ] & dp_ctl[DP_MEM_WRITE]}, 32'd0);
    end
  end

  initial begin
    reset_n = 1'b0; stop = 1'b0; con_ff = 1'b0; ir = 32'h0;
    inv_en = 1'b1;

    // Reset held two cycles
    tick(); tick();
    expect_out("rst", 6'd0, 22'd0, 1'b0);
    reset_n = 1'b1;
    tick();
    expect_out("t0_first", 6'd0, M_T0, 1'b1);

    // add R3,R1,R2
    ir = 32'h19890000;
    tick(); expect_out("add_t1", 6'd0, M_T1, 1'b1);
    tick(); expect_out("add_t2", 6'd0, M_T2, 1'b1);
    tick(); expect_out("add_t3", RS_GRB | RS_ROUT, 22'd1 << DP_Y_IN, 1'b1);
    tick(); expect_out("add_t4", RS_GRC | RS_ROUT, 22'd1 << DP_Z_IN, 1'b1);
    check("add_alu", {27'd0, alu_op}, 32'd3);
    tick(); expect_out("add_t5", RS_GRA | RS_RIN, 22'd1 << DP_Z_LO_OUT, 1'b1);
    tick(); expect_out("add_next", 6'd0, M_T0, 1'b1);

    // ld R2,0x65(R0)
    ir = 32'h01000065;
    tick(); tick(); tick();
    expect_out("ld_t3", RS_GRB | RS_BA, 22'd1 << DP_Y_IN, 1'b1);
    tick(); expect_out("ld_t4", 6'd0, (22'd1 << DP_C_OUT) | (22'd1 << DP_Z_IN), 1'b1);
    check("ld_alu", {27'd0, alu_op}, {27'd0, ALU_ADD});
    tick(); expect_out("ld_t5", 6'd0, (22'd1 << DP_Z_LO_OUT) | (22'd1 << DP_MAR_IN), 1'b1);
    tick(); expect_out("ld_t6", 6'd0, (22'd1 << DP_MEM_READ) | (22'd1 << DP_MDR_IN), 1'b1);
    tick(); expect_out("ld_t7", RS_GRA | RS_RIN, 22'd1 << DP_MDR_OUT, 1'b1);
    tick(); expect_out("ld_next", 6'd0, M_T0, 1'b1);

    // br taken then not taken
    ir = 32'h9A800004;
    for (int pass = 0; pass < 2; pass++) begin
      con_ff = (pass == 0);
      tick(); tick(); tick();
      expect_out("br_t3", RS_GRA | RS_ROUT, 22'd1 << DP_CON_IN, 1'b1);
      tick(); tick(); tick();
      if (pass == 0)
        expect_out("br_t6_taken", 6'd0, (22'd1 << DP_Z_LO_OUT) | (22'd1 << DP_PC_IN), 1'b1);
      else
        expect_out("br_t6_not", 6'd0, 22'd1 << DP_Z_LO_OUT, 1'b1);
      tick(); expect_out("br_next", 6'd0, M_T0, 1'b1);
    end
    con_ff = 1'b0;

    // nop ends after T2
    ir = 32'hD0000000;
    tick(); tick(); tick();
    expect_out("nop_next", 6'd0, M_T0, 1'b1);

    // stop during T4 of add: finishes T5 then pauses
    ir = 32'h19890000;
    tick(); tick(); tick(); tick();
    stop = 1'b1;
    tick(); expect_out("stop_t5", RS_GRA | RS_RIN, 22'd1 << DP_Z_LO_OUT, 1'b1);
    tick(); expect_out("pause", 6'd0, 22'd0, 1'b0);
    tick(); expect_out("pause_hold", 6'd0, 22'd0, 1'b0);
    stop = 1'b0;
    tick(); expect_out("pause_exit", 6'd0, M_T0, 1'b1);

    // halt is sticky regardless of stop
    ir = 32'hD8000000;
    tick(); tick(); tick();
    expect_out("halt_t3", 6'd0, 22'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      stop = i[0];
      tick();
      check("halt_run", {31'd0, run}, 32'd0);
      check("halt_dp", {10'd0, dp_ctl}, 32'd0);
    end
    stop = 1'b0;
    reset_n = 1'b0;
    tick(); expect_out("halt_rst", 6'd0, 22'd0, 1'b0);
    reset_n = 1'b1;
    tick(); expect_out("halt_exit", 6'd0, M_T0, 1'b1);

    // st aborted by reset at T6: no mem_write ever
    ir = 32'h11000065;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("st_no_wr", {31'd0, dp_ctl[DP_MEM_WRITE]}, 32'd0);
    end
    expect_out("st_t6", RS_GRA | RS_ROUT, 22'd1 << DP_MDR_IN, 1'b1);
    reset_n = 1'b0;
    tick(); expect_out("st_rst", 6'd0, 22'd0, 1'b0);
    reset_n = 1'b1;
    tick(); expect_out("st_refetch", 6'd0, M_T0, 1'b1);

    inv_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
